// File: rtl/control_iter_div_sqrt_mvp.sv
// Radix-2 non-restoring div/sqrt sequencer; one result bit per cycle, WIDTH+2 cycles start->Done.
// No backpressure: starts are taken only while Ready_SO. Sticky logic exists only with DIV_SQRT_STICKY_EN.
module control_iter_div_sqrt_mvp #(
  parameter int WIDTH = 24
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             Div_start_SI,
  input  logic             Sqrt_start_SI,
  input  logic             Kill_SI,
  input  logic             Exp_odd_SI,
  input  logic [WIDTH-1:0] Mant_a_DI,
  input  logic [WIDTH-1:0] Mant_b_DI,
  output logic             Ready_SO,
  output logic             Busy_SO,
  output logic             Done_SO,
  output logic [WIDTH:0]   Result_DO,
  output logic             Sticky_DO
);
  // The sqrt remainder grows to about 2*root before the x4 shift, so it needs two bits beyond the div case.
  localparam int RW = WIDTH + 5;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sqrt_q, sqrt_d;
  logic             neg_q, neg_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH+1:0] rad_q, rad_d;
  logic [WIDTH:0]   root_q, root_d;
  logic [WIDTH:0]   res_q, res_d;
  logic [RW-1:0]    base, dop, sum;
  logic             new_bit, last_iter;

  assign last_iter = (cnt_q == CW'(WIDTH));

  // Sqrt shifts in two radicand bits per step; division shifts by one, except on the first step.
  always_comb begin
    if (sqrt_q)
      base = {rem_q[RW-3:0], rad_q[WIDTH+1:WIDTH]};
    else if (cnt_q == '0)
      base = rem_q;
    else
      base = {rem_q[RW-2:0], 1'b0};
    dop     = sqrt_q ? {{(RW-WIDTH-3){1'b0}}, root_q, neg_q, 1'b1}
                     : {{(RW-WIDTH){1'b0}}, div_q};
    sum     = base + (neg_q ? dop : ~dop) + {{(RW-1){1'b0}}, ~neg_q};
    new_bit = ~sum[RW-1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sqrt_d  = sqrt_q;
    neg_d   = neg_q;
    rem_d   = rem_q;
    div_d   = div_q;
    rad_d   = rad_q;
    root_d  = root_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if ((Div_start_SI || Sqrt_start_SI) && !Kill_SI) begin
          state_d = ITER;
          cnt_d   = '0;
          sqrt_d  = !Div_start_SI;
          neg_d   = 1'b0;
          root_d  = '0;
          div_d   = Mant_b_DI;
          rem_d   = Div_start_SI ? {{(RW-WIDTH){1'b0}}, Mant_a_DI} : '0;
          rad_d   = Exp_odd_SI ? {1'b0, Mant_a_DI, 1'b0} : {2'b00, Mant_a_DI};
        end
      end
      ITER: begin
        rem_d  = sum;
        neg_d  = sum[RW-1];
        root_d = {root_q[WIDTH-1:0], new_bit};
        rad_d  = {rad_q[WIDTH-1:0], 2'b00};
        if (last_iter) begin
          state_d = DONE;
          res_d   = {root_q[WIDTH-1:0], new_bit};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Kill_SI) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sqrt_q  <= 1'b0;
      neg_q   <= 1'b0;
      rem_q   <= '0;
      div_q   <= '0;
      rad_q   <= '0;
      root_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sqrt_q  <= sqrt_d;
      neg_q   <= neg_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      res_q   <= res_d;
    end
  end

  assign Ready_SO  = (state_q == IDLE);
  assign Busy_SO   = (state_q == ITER);
  assign Done_SO   = (state_q == DONE);
  assign Result_DO = res_q;

`ifdef DIV_SQRT_STICKY_EN
  // A negative final remainder is restored by adding back B (div) or 2*root+1 (sqrt).
  logic [RW-1:0] fix_add, rem_fix;
  logic          sticky_now, sticky_q;

  assign fix_add    = sqrt_q ? {{(RW-WIDTH-2){1'b0}}, root_q, 1'b1}
                             : {{(RW-WIDTH){1'b0}}, div_q};
  assign rem_fix    = rem_q[RW-1] ? (rem_q + fix_add) : rem_q;
  assign sticky_now = |rem_fix;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI)
      sticky_q <= 1'b0;
    else if (state_q == DONE)
      sticky_q <= sticky_now;
  end

  assign Sticky_DO = (state_q == DONE) ? sticky_now : sticky_q;
`else
  assign Sticky_DO = 1'b0;
`endif

endmodule

// File: tb/tb_control_iter_div_sqrt_mvp.sv
// Scoreboard bench for control_iter_div_sqrt_mvp with hand-computed directed vectors (WIDTH=24).
module tb_control_iter_div_sqrt_mvp;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         div_s = 1'b0, sqrt_s = 1'b0, kill = 1'b0, odd = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, busy, done, sticky;
  logic [W:0]   result;

  typedef struct {
    logic [W:0] res;
    logic       st;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [W:0] last_res = '0;

  control_iter_div_sqrt_mvp #(.WIDTH(W)) dut (
    .Clk_CI       (clk),
    .Rst_RBI      (rst_n),
    .Div_start_SI (div_s),
    .Sqrt_start_SI(sqrt_s),
    .Kill_SI      (kill),
    .Exp_odd_SI   (odd),
    .Mant_a_DI    (a),
    .Mant_b_DI    (b),
    .Ready_SO     (ready),
    .Busy_SO      (busy),
    .Done_SO      (done),
    .Result_DO    (result),
    .Sticky_DO    (sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic st_exp(input logic s);
`ifdef DIV_SQRT_STICKY_EN
    return s;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every Done pulse must match the oldest pending expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Done_SO=1 with no pending operation, required 0");
      end else begin
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("sticky", 32'(sticky), 32'(e.st));
        chk("latency", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; waits for Ready, drives a one-cycle request, returns at the next negedge.
  task automatic issue(input logic dv, input logic sq, input logic kl,
                       input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic od,
                       input logic push, input logic [W:0] er, input logic es);
    int n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: Ready_SO=0 after %0d cycles, required 1", n);
    end
    div_s = dv; sqrt_s = sq; kill = kl; a = ta; b = tb_; odd = od;
    if (push) begin
      sb.push_back('{er, st_exp(es), cyc + W + 2});
      last_res = er;
    end
    @(negedge clk);
    div_s = 1'b0; sqrt_s = 1'b0; kill = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  32'(ready),  32'd1);
    chk({tag, "_busy"},   32'(busy),   32'd0);
    chk({tag, "_done"},   32'(done),   32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_sticky"}, 32'(sticky), 32'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, issued back-to-back (each start lands in the IDLE cycle after DONE).
    issue(1, 0, 0, 24'h800000, 24'h800000, 0, 1, 25'h1000000, 0);
    issue(1, 0, 0, 24'hC00000, 24'h800000, 0, 1, 25'h1800000, 0);
    issue(1, 0, 0, 24'h800000, 24'hC00000, 0, 1, 25'h0AAAAAA, 1);
    issue(0, 1, 0, 24'h800000, 24'h000000, 1, 1, 25'h1000000, 0);
    issue(0, 1, 0, 24'h800000, 24'h000000, 0, 1, 25'h0B504F3, 1);
    issue(1, 0, 0, 24'hFFFFFF, 24'h800000, 0, 1, 25'h1FFFFFE, 0);
    issue(1, 0, 0, 24'hFFFFFF, 24'hFFFFFF, 0, 1, 25'h1000000, 0);
    issue(1, 0, 0, 24'h800000, 24'hFFFFFF, 0, 1, 25'h0800000, 1);
    issue(0, 1, 0, 24'h900000, 24'h000000, 0, 1, 25'h0C00000, 0);
    issue(0, 1, 0, 24'hC80000, 24'h000000, 1, 1, 25'h1400000, 0);

    // Both starts together: division wins.
    issue(1, 1, 0, 24'hC00000, 24'h800000, 0, 1, 25'h1800000, 0);

    // Start pulses and operand changes during ITER are ignored; latency checked by the monitor.
    issue(1, 0, 0, 24'h800000, 24'hC00000, 0, 1, 25'h0AAAAAA, 1);
    repeat (4) @(negedge clk);
    div_s = 1'b1; sqrt_s = 1'b1; a = 24'h123456; b = 24'h9ABCDE;
    @(negedge clk);
    div_s = 1'b0; sqrt_s = 1'b0;
    repeat (5) @(negedge clk);
    sqrt_s = 1'b1;
    @(negedge clk);
    sqrt_s = 1'b0;

    // Kill at iteration 10: back to IDLE next cycle, no Done, Result unchanged.
    issue(1, 0, 0, 24'hFFFFFF, 24'h800000, 0, 0, '0, 0);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_ready",  32'(ready),  32'd1);
    chk("kill_busy",   32'(busy),   32'd0);
    chk("kill_result", 32'(result), 32'(last_res));
    repeat (40) @(negedge clk);
    chk("kill_result_held", 32'(result), 32'(last_res));

    // Kill together with a start in IDLE: start dropped.
    issue(1, 0, 1, 24'hC00000, 24'h800000, 0, 0, '0, 0);
    chk("killstart_ready", 32'(ready), 32'd1);
    chk("killstart_busy",  32'(busy),  32'd0);

    // Normal operation after a kill.
    issue(0, 1, 0, 24'h800000, 24'h000000, 0, 1, 25'h0B504F3, 1);

    // Asynchronous reset in the middle of ITER.
    issue(1, 0, 0, 24'hC00000, 24'h800000, 0, 0, '0, 0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 1, 0, 24'hC80000, 24'h000000, 1, 1, 25'h1400000, 0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
